// File: rtl/minisys_cpu.sv
// minisys_cpu: single-cycle 32-bit MIPS subset (Minisys-1) core with
// instruction ROM, data RAM and a memory-mapped LED/switch port.
//
// Ports:
//   clk        system clock, every state update on the rising edge
//   fpga_rst   synchronous active-high reset
//   start_uart download mode; holds the core in reset while high
//   rx         UART receive line, not used by the core
//   tx         UART transmit line, held idle (1)
//   io_rdata   24 switch inputs, read at 0xFFFFFC70
//   io_wdata   24-bit LED register, written at 0xFFFFFC60
module minisys_cpu #(
    parameter int    IMEM_WORDS = 16384,
    parameter int    DMEM_WORDS = 16384,
    parameter string IMEM_INIT  = "prgmip32.mem",
    parameter string DMEM_INIT  = "dmem32.mem"
) (
    input  logic        clk,
    input  logic        fpga_rst,
    input  logic        start_uart,
    input  logic        rx,
    output logic        tx,
    input  logic [23:0] io_rdata,
    output logic [23:0] io_wdata
);
    localparam int IA = $clog2(IMEM_WORDS);
    localparam int DA = $clog2(DMEM_WORDS);

    logic [31:0] imem [IMEM_WORDS];
    logic [31:0] dmem [DMEM_WORDS];
    logic [31:0] gpr  [32];
    logic [31:0] pc;

    // Download mode is indistinguishable from reset for the core.
    logic core_rst;
    assign core_rst = fpga_rst | start_uart;

    logic [31:0] instr, rs_v, rt_v, imm_s, imm_z, pc4, addr, ld_data, alu_r;
    logic [31:0] next_pc, wr_data;
    logic [5:0]  op, funct;
    logic [4:0]  rs_a, rt_a, rd_a, shamt, wr_addr;
    logic        wr_en, dmem_we, led_we, is_io, alu_ok;

    assign instr = imem[pc[IA+1:2]];
    assign op    = instr[31:26];
    assign rs_a  = instr[25:21];
    assign rt_a  = instr[20:16];
    assign rd_a  = instr[15:11];
    assign shamt = instr[10:6];
    assign funct = instr[5:0];

    assign rs_v  = (rs_a == 5'd0) ? 32'd0 : gpr[rs_a];
    assign rt_v  = (rt_a == 5'd0) ? 32'd0 : gpr[rt_a];
    assign imm_s = {{16{instr[15]}}, instr[15:0]};
    assign imm_z = {16'h0, instr[15:0]};
    assign pc4   = pc + 32'd4;
    assign addr  = rs_v + imm_s;
    assign is_io = &addr[31:10];
    assign tx    = 1'b1;

    // Word accesses only: addr[1:0] is dropped; rx is unused this revision.
    logic unused;
    assign unused = ^{rx, addr[1:0]};

    // Load path: I/O window decodes addr[9:2], everything else aliases into RAM.
    always_comb begin
        ld_data = 32'd0;
        if (!is_io)
            ld_data = dmem[addr[DA+1:2]];
        else if (addr[9:2] == 8'h18)
            ld_data = {8'h0, io_wdata};
        else if (addr[9:2] == 8'h1C)
            ld_data = {8'h0, io_rdata};
    end

    // R-type ALU; overflow never traps, so add/sub share the unsigned path.
    always_comb begin
        alu_r  = 32'd0;
        alu_ok = 1'b1;
        case (funct)
            6'h20, 6'h21: alu_r = rs_v + rt_v;
            6'h22, 6'h23: alu_r = rs_v - rt_v;
            6'h24:        alu_r = rs_v & rt_v;
            6'h25:        alu_r = rs_v | rt_v;
            6'h26:        alu_r = rs_v ^ rt_v;
            6'h27:        alu_r = ~(rs_v | rt_v);
            6'h2A:        alu_r = {31'd0, $signed(rs_v) < $signed(rt_v)};
            6'h2B:        alu_r = {31'd0, rs_v < rt_v};
            6'h00:        alu_r = rt_v << shamt;
            6'h02:        alu_r = rt_v >> shamt;
            6'h03:        alu_r = $signed(rt_v) >>> shamt;
            6'h04:        alu_r = rt_v << rs_v[4:0];
            6'h06:        alu_r = rt_v >> rs_v[4:0];
            6'h07:        alu_r = $signed(rt_v) >>> rs_v[4:0];
            default:      alu_ok = 1'b0;   // jr and unknown functs write nothing
        endcase
    end

    // Main decode: next PC, register write-back and store steering.
    always_comb begin
        next_pc = pc4;
        wr_en   = 1'b0;
        wr_addr = rt_a;
        wr_data = 32'd0;
        dmem_we = 1'b0;
        led_we  = 1'b0;
        case (op)
            6'h00: begin
                if (funct == 6'h08) begin
                    next_pc = rs_v;
                end else begin
                    wr_en   = alu_ok;
                    wr_addr = rd_a;
                    wr_data = alu_r;
                end
            end
            6'h02: next_pc = {pc4[31:28], instr[25:0], 2'b00};
            6'h03: begin
                next_pc = {pc4[31:28], instr[25:0], 2'b00};
                wr_en   = 1'b1;
                wr_addr = 5'd31;
                wr_data = pc4;
            end
            6'h04: if (rs_v == rt_v) next_pc = pc4 + {imm_s[29:0], 2'b00};
            6'h05: if (rs_v != rt_v) next_pc = pc4 + {imm_s[29:0], 2'b00};
            6'h08, 6'h09: begin wr_en = 1'b1; wr_data = rs_v + imm_s; end
            6'h0A: begin wr_en = 1'b1; wr_data = {31'd0, $signed(rs_v) < $signed(imm_s)}; end
            6'h0B: begin wr_en = 1'b1; wr_data = {31'd0, rs_v < imm_s}; end
            6'h0C: begin wr_en = 1'b1; wr_data = rs_v & imm_z; end
            6'h0D: begin wr_en = 1'b1; wr_data = rs_v | imm_z; end
            6'h0E: begin wr_en = 1'b1; wr_data = rs_v ^ imm_z; end
            6'h0F: begin wr_en = 1'b1; wr_data = {instr[15:0], 16'h0}; end
            6'h23: begin wr_en = 1'b1; wr_data = ld_data; end
            6'h2B: begin
                if (!is_io) dmem_we = 1'b1;
                else        led_we  = (addr[9:2] == 8'h18);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (core_rst) begin
            pc       <= 32'd0;
            io_wdata <= 24'd0;
            for (int i = 0; i < 32; i++) gpr[i] <= 32'd0;
        end else begin
            pc <= next_pc;
            if (wr_en && wr_addr != 5'd0) gpr[wr_addr] <= wr_data;
            if (led_we) io_wdata <= rt_v[23:0];
        end
    end

    // RAM survives reset; stores are simply suppressed while held idle.
    always_ff @(posedge clk) begin
        if (!core_rst && dmem_we) dmem[addr[DA+1:2]] <= rt_v;
    end
endmodule

// File: tb/tb_minisys_cpu.sv
// tb_minisys_cpu: runs small programs on minisys_cpu next to an
// instruction-level reference model; directed table, hand sequences for
// reset / LED ordering / start_uart, then random programs.
module tb_minisys_cpu;
    localparam int IW = 256;
    localparam int DW = 256;

    logic        clk = 1'b0;
    logic        fpga_rst = 1'b0;
    logic        start_uart = 1'b0;
    logic        rx = 1'b1;
    logic        tx;
    logic [23:0] io_rdata = 24'd0;
    logic [23:0] io_wdata;

    minisys_cpu #(.IMEM_WORDS(IW), .DMEM_WORDS(DW), .IMEM_INIT(""), .DMEM_INIT("")) dut (
        .clk(clk), .fpga_rst(fpga_rst), .start_uart(start_uart), .rx(rx),
        .tx(tx), .io_rdata(io_rdata), .io_wdata(io_wdata));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Architectural reference state
    logic [31:0] m_imem [IW];
    logic [31:0] m_dmem [DW];
    logic [31:0] m_reg  [32];
    logic [31:0] m_pc;
    logic [23:0] m_led;
    logic [31:0] prog [$];

    function automatic logic [31:0] R(input int fn, input int rs, input int rt, input int rd, input int sh);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction
    function automatic logic [31:0] I(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction
    function automatic logic [31:0] J(input int op, input int tgt);
        return {6'(op), 26'(tgt)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One instruction of the ISA, straight from the instruction semantics.
    task automatic m_step(input logic rst, input logic [23:0] swv);
        logic [31:0] ins, a, b, se, ze, pc4, ea, res;
        logic [4:0]  dst;
        if (rst) begin
            m_pc = 0; m_led = 0;
            for (int i = 0; i < 32; i++) m_reg[i] = 0;
            return;
        end
        ins = m_imem[(m_pc / 4) % IW];
        a   = m_reg[ins[25:21]];
        b   = m_reg[ins[20:16]];
        se  = {{16{ins[15]}}, ins[15:0]};
        ze  = {16'h0, ins[15:0]};
        pc4 = m_pc + 4;
        m_pc = pc4;
        ea  = a + se;
        dst = 0;
        res = 0;
        case (ins[31:26])
            6'd0: begin
                dst = ins[15:11];
                case (ins[5:0])
                    6'd32, 6'd33: res = a + b;
                    6'd34, 6'd35: res = a - b;
                    6'd36: res = a & b;
                    6'd37: res = a | b;
                    6'd38: res = a ^ b;
                    6'd39: res = ~(a | b);
                    6'd42: res = ($signed(a) < $signed(b)) ? 1 : 0;
                    6'd43: res = (a < b) ? 1 : 0;
                    6'd0:  res = b << ins[10:6];
                    6'd2:  res = b >> ins[10:6];
                    6'd3:  res = $signed(b) >>> ins[10:6];
                    6'd4:  res = b << a[4:0];
                    6'd6:  res = b >> a[4:0];
                    6'd7:  res = $signed(b) >>> a[4:0];
                    6'd8:  begin m_pc = a; dst = 0; end
                    default: dst = 0;
                endcase
            end
            6'd2: m_pc = {pc4[31:28], ins[25:0], 2'b00};
            6'd3: begin m_pc = {pc4[31:28], ins[25:0], 2'b00}; dst = 31; res = pc4; end
            6'd4: if (a == b) m_pc = pc4 + (se << 2);
            6'd5: if (a != b) m_pc = pc4 + (se << 2);
            6'd8, 6'd9: begin dst = ins[20:16]; res = a + se; end
            6'd10: begin dst = ins[20:16]; res = ($signed(a) < $signed(se)) ? 1 : 0; end
            6'd11: begin dst = ins[20:16]; res = (a < se) ? 1 : 0; end
            6'd12: begin dst = ins[20:16]; res = a & ze; end
            6'd13: begin dst = ins[20:16]; res = a | ze; end
            6'd14: begin dst = ins[20:16]; res = a ^ ze; end
            6'd15: begin dst = ins[20:16]; res = {ins[15:0], 16'h0}; end
            6'd35: begin
                dst = ins[20:16];
                if (ea[31:10] == 22'h3FFFFF)
                    res = ((ea & 32'h3FC) == 32'h060) ? {8'h0, m_led} :
                          ((ea & 32'h3FC) == 32'h070) ? {8'h0, swv} : 0;
                else
                    res = m_dmem[(ea / 4) % DW];
            end
            6'd43: begin
                if (ea[31:10] == 22'h3FFFFF) begin
                    if ((ea & 32'h3FC) == 32'h060) m_led = b[23:0];
                end else
                    m_dmem[(ea / 4) % DW] = b;
            end
            default: ;
        endcase
        if (dst != 0) m_reg[dst] = res;
    endtask

    task automatic tick();
        m_step(fpga_rst | start_uart, io_rdata);
        @(posedge clk);
        @(negedge clk);
        chk("pc", dut.pc, m_pc);
        chk("led", {8'h0, io_wdata}, {8'h0, m_led});
        chk("tx", {31'd0, tx}, 32'd1);
    endtask

    task automatic load();
        logic [31:0] w;
        for (int i = 0; i < IW; i++) begin
            w = (i < prog.size()) ? prog[i] : I(43, 0, 0, 0);   // sw $0,0($0) filler
            dut.imem[i] = w;
            m_imem[i]   = w;
        end
    endtask

    task automatic do_reset();
        fpga_rst = 1'b1;
        tick(); tick();
        fpga_rst = 1'b0;
    endtask

    task automatic build(input int id);
        prog.delete();
        if (id != 0) begin
            prog.push_back(I(15, 0, 1, 'hFFFF));
            prog.push_back(I(13, 1, 1, 'hFC00));
        end
        case (id)
            1: prog = {prog, I(35,1,2,'h70), I(43,1,2,'h60), J(2,2)};
            2: prog = {prog, I(8,0,3,-5), R(43,0,3,4,0), I(43,1,4,'h60), R(42,3,0,5,0),
                       I(43,1,5,'h60), R(3,0,3,6,1), I(43,1,6,'h60), R(39,0,0,7,0),
                       I(43,1,7,'h60), I(8,0,0,7), I(43,1,0,'h60), J(2,13)};
            3: prog = {prog, I(15,0,2,'h1234), I(13,2,2,'h5678), I(43,0,2,'h40), I(35,0,3,'h40),
                       I(43,1,3,'h60), I(35,1,4,0), I(43,1,4,'h60), J(2,9)};
            4: prog = {prog, I(8,0,2,1), I(4,0,0,1), I(8,0,2,9), I(43,1,2,'h60),
                       I(5,0,0,1), I(8,0,2,2), J(3,12), I(8,0,2,3), I(43,1,2,'h60),
                       J(2,11), I(43,1,2,'h60), R(8,31,0,0,0)};
            default: ;
        endcase
    endtask

    typedef struct {
        string       name;
        int          prog;
        bit          restart;
        logic [23:0] sw;
        int          cycles;
        logic [23:0] exp;
    } vec_t;
    vec_t vecs [$];

    int          fns [17] = '{32,33,34,35,36,37,38,39,42,43,0,2,3,4,6,7,1};
    int          iops [8] = '{8,9,10,11,12,13,14,15};
    int          ioffs [4] = '{'h60,'h70,'h64,0};
    int          at_t [7] = '{4,5,7,8,9,11,13};
    logic [23:0] at_v [7] = '{24'h0,24'h1,24'h1,24'h1,24'hFFFFFD,24'hFFFFFF,24'h0};
    int          cf_t [6] = '{4,5,8,9,11,12};
    logic [23:0] cf_v [6] = '{24'h0,24'h1,24'h1,24'h2,24'h2,24'h3};

    initial begin
        logic [31:0] acc;
        int j;
        for (int i = 0; i < DW; i++) begin dut.dmem[i] = 0; m_dmem[i] = 0; end

        // Reset held 5 cycles over a ROM of sw nops
        build(0); load();
        fpga_rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rst_pc", dut.pc, 32'd0);
            chk("rst_led", {8'h0, io_wdata}, 32'd0);
        end
        fpga_rst = 1'b0;
        tick(); chk("rel_pc1", dut.pc, 32'd4);
        tick(); chk("rel_pc2", dut.pc, 32'd8);

        vecs.push_back('{"sw2led_a",    1, 1'b1, 24'h0A0078, 6,  24'h0A0078});
        vecs.push_back('{"sw2led_hold", 1, 1'b0, 24'h0A0078, 2,  24'h0A0078});
        vecs.push_back('{"sw2led_b",    1, 1'b0, 24'hEF0000, 3,  24'hEF0000});
        vecs.push_back('{"mem_rw",      3, 1'b1, 24'h000000, 7,  24'h345678});
        vecs.push_back('{"io_unmapped", 3, 1'b0, 24'h000000, 2,  24'h000000});
        vecs.push_back('{"cf_final",    4, 1'b1, 24'h000000, 14, 24'h000003});
        foreach (vecs[v]) begin
            io_rdata = vecs[v].sw;
            if (vecs[v].restart) begin build(vecs[v].prog); load(); do_reset(); end
            repeat (vecs[v].cycles) tick();
            chk(vecs[v].name, {8'h0, io_wdata}, {8'h0, vecs[v].exp});
        end

        // ALU results through the LED, one marker per store
        build(2); load(); do_reset();
        j = 0;
        for (int t = 1; t <= 13; t++) begin
            tick();
            if (j < 7 && t == at_t[j]) begin
                chk($sformatf("alu_led_t%0d", t), {8'h0, io_wdata}, {8'h0, at_v[j]});
                j++;
            end
        end

        // Branch / jal / jr ordering
        build(4); load(); do_reset();
        j = 0;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (t == 8)  begin chk("jal_pc", dut.pc, 32'h30); chk("jal_ra", dut.gpr[31], 32'h24); end
            if (t == 10) chk("jr_pc", dut.pc, 32'h24);
            if (j < 6 && t == cf_t[j]) begin
                chk($sformatf("cf_led_t%0d", t), {8'h0, io_wdata}, {8'h0, cf_v[j]});
                j++;
            end
        end

        // start_uart mid-program acts as reset, then the program restarts
        tick(); tick();
        start_uart = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            acc = 0;
            for (int r = 0; r < 32; r++) acc |= dut.gpr[r];
            chk("uart_pc", dut.pc, 32'd0);
            chk("uart_led", {8'h0, io_wdata}, 32'd0);
            chk("uart_gpr", acc, 32'd0);
        end
        start_uart = 1'b0;
        repeat (4) tick();
        chk("uart_led_t4", {8'h0, io_wdata}, 32'd0);
        tick();
        chk("uart_led_t5", {8'h0, io_wdata}, 32'd1);

        // Random straight-line programs with forward branches and memory traffic
        for (int it = 0; it < 20; it++) begin
            build(0);
            prog.push_back(I(15, 0, 1, 'hFFFF));
            prog.push_back(I(13, 1, 1, 'hFC00));
            for (int k = 0; k < 24; k++) begin
                int r, d, s, t, lim;
                r = $urandom_range(0, 10);
                d = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(2, 7);
                s = $urandom_range(0, 7);
                t = $urandom_range(0, 7);
                lim = (23 - k < 3) ? 23 - k : 3;
                case (r)
                    0, 1, 2: prog.push_back(R(fns[$urandom_range(0, 16)], s, t, d, $urandom_range(0, 31)));
                    3, 4:    prog.push_back(I(iops[$urandom_range(0, 7)], s, d, $urandom_range(0, 'hFFFF)));
                    5:       prog.push_back(I(43, 1, t, ioffs[$urandom_range(0, 3)]));
                    6:       prog.push_back(I(35, 1, d, ioffs[$urandom_range(0, 3)]));
                    7:       prog.push_back(I(43, 0, t, 4 * $urandom_range(0, 15)));
                    8:       prog.push_back(I(35, 0, d, 4 * $urandom_range(0, 15)));
                    9:       prog.push_back(I($urandom_range(4, 5), s, t, $urandom_range(0, lim)));
                    default: prog.push_back(I(20, s, d, $urandom_range(0, 'hFFFF)));
                endcase
            end
            prog.push_back(J(2, 26));
            load();
            io_rdata = 24'($urandom);
            do_reset();
            repeat (40) begin
                io_rdata = 24'($urandom);
                tick();
            end
            for (int r = 1; r < 32; r++) chk($sformatf("rnd%0d_r%0d", it, r), dut.gpr[r], m_reg[r]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
